alu_rs_scheduler: RTL and testbench
===================================

ALU_RS_SCHEDULER -- requirements
Module: alu_rs_scheduler

Interface
REQ-001 Param RS_SIZE, 8, number of reservation-station entries (power of two, 2..16).
REQ-002 Param DATA_W, 32, operand/result width; ROB_W, 4, ROB index width; OPT_W, 6, opcode width (0 = no-op).
REQ-003 clk_in  in  1  single clock; all state updates on rising edge.
REQ-004 rst_in  in  1  reset, synchronous, active-low.
REQ-005 rdy_in  in  1  global enable; low freezes all state.
REQ-006 flush_in  in  1  misprediction clear.
REQ-007 disp_valid/disp_opt/disp_rob  in  1/OPT_W/ROB_W  dispatch request, opcode, destination ROB index.
REQ-008 disp_qj_busy/disp_qj/disp_vj  in  1/ROB_W/DATA_W  rs1 pending flag, producer tag, value; same triple disp_qk_busy/disp_qk/disp_vk for rs2.
REQ-009 disp_imm/disp_pc  in  DATA_W each  immediate and instruction PC.
REQ-010 full_out  out  1  no free entry.
REQ-011 cdb_valid/cdb_rob/cdb_value  in  1/ROB_W/DATA_W  common-data-bus broadcast for wakeup.
REQ-012 alu_opt/alu_rs1/alu_rs2/alu_imm/alu_pc/alu_rob  out  OPT_W/DATA_W x4/ROB_W  registered issue operands to the ALU.
REQ-013 alu_res/alu_pc_in/alu_jump_in/alu_rob_in  in  DATA_W/DATA_W/1/ROB_W  combinational ALU outputs.
REQ-014 out_valid/out_res/out_pc/out_jump/out_rob  out  1/DATA_W/DATA_W/1/ROB_W  result register to CDB arbiter.
REQ-015 out_ready  in  1  arbiter accepts result when out_valid & out_ready.

Function
REQ-016 Dispatch: when disp_valid & !full_out, the lowest-index free entry is written; dispatch while full is ignored.
REQ-017 Dispatch forward: if cdb_valid and cdb_rob equals a pending disp_qj/disp_qk in the same cycle, that operand is stored ready with cdb_value.
REQ-018 Wakeup: every busy entry with a pending operand whose tag equals cdb_rob under cdb_valid captures cdb_value and clears pending.
REQ-019 Entry ready = busy & both operands not pending, evaluated on registered state (an entry woken this cycle is selectable next cycle).
REQ-020 Issue stage register (alu_*) advances when empty or when the output register will be empty/drained this cycle (out_valid==0 or out_ready==1).
REQ-021 On advance, one ready entry moves into the issue register and frees its slot; no ready entry loads alu_opt=0 (bubble).
REQ-022 Output register captures ALU result at the edge after issue when alu_opt!=0 and able to advance; holds stable while out_valid & !out_ready.
REQ-023 Latency: dispatch with both operands ready at edge E0 -> alu_* valid after E1 -> out_valid after E2; throughput one instruction/cycle with out_ready high.
REQ-024 Simultaneous dispatch and issue in one cycle permitted; a slot freed by issue is reusable next cycle, not same cycle.
REQ-025 full_out = all RS_SIZE entries busy, combinational from busy bits.
REQ-026 flush_in (rdy_in high) clears all busy bits, issue register (alu_opt=0) and out_valid at the edge; overrides dispatch, issue, capture.
REQ-027 rdy_in low: no dispatch, wakeup, issue or capture; outputs hold; CDB broadcasts during this time are lost (upstream guarantees none).

Reset
REQ-028 rst_in low at an edge: all entries free, alu_opt=0, all alu_* and out_* data 0, out_valid=0, out_jump=0; takes precedence over flush and rdy_in.
REQ-029 Reset asserted mid-operation discards all in-flight instructions with no output pulse.

Configuration
REQ-030 Macro ALU_SCHED_OLDEST_EN defined: selection picks the ready entry dispatched earliest (per-entry age tracking, RS_SIZE-deep ordering).
REQ-031 Macro ALU_SCHED_OLDEST_EN undefined: selection picks the lowest-index ready entry; no age state synthesized.

Verification
REQ-032 Dispatch ADD rob=3, vj=5, vk=7, all ready, out_ready=1 -> out_valid after 2nd edge, out_res=12, out_rob=3, single-cycle pulse.
REQ-033 Dispatch SUB rob=2 with qj=1 pending; CDB rob=1 value=10 two cycles later, vk=4 -> out_res=6 exactly 2 edges after wakeup edge.
REQ-034 Fill 8 entries pending on rob=9 -> full_out=1, 9th dispatch ignored; broadcast rob=9 -> 8 results in consecutive cycles, full_out drops after first issue.
REQ-035 Hold out_ready=0 for 5 cycles with 3 ready entries -> out_* stable, no entry lost; release -> 3 results, each once.
REQ-036 Entries at idx0 (dispatched later) and idx1 (earlier) ready same cycle -> issue order idx1,idx0 with ALU_SCHED_OLDEST_EN, idx0,idx1 without.
REQ-037 flush_in with 4 busy entries and out_valid=1 -> next cycle full_out=0, out_valid=0, alu_opt=0; rst_in low mid-stream -> same, no stray output.

Source files
------------

// File: rtl/alu_rs_scheduler.sv
// ALU reservation station with operand wakeup, single issue stage and a result register.
// Define ALU_SCHED_OLDEST_EN to issue the oldest ready entry instead of the lowest-index one.
module alu_rs_scheduler #(
  parameter int unsigned RS_SIZE = 8,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ROB_W   = 4,
  parameter int unsigned OPT_W   = 6
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              flush_in,
  input  logic              disp_valid,
  input  logic [OPT_W-1:0]  disp_opt,
  input  logic [ROB_W-1:0]  disp_rob,
  input  logic              disp_qj_busy,
  input  logic [ROB_W-1:0]  disp_qj,
  input  logic [DATA_W-1:0] disp_vj,
  input  logic              disp_qk_busy,
  input  logic [ROB_W-1:0]  disp_qk,
  input  logic [DATA_W-1:0] disp_vk,
  input  logic [DATA_W-1:0] disp_imm,
  input  logic [DATA_W-1:0] disp_pc,
  output logic              full_out,
  input  logic              cdb_valid,
  input  logic [ROB_W-1:0]  cdb_rob,
  input  logic [DATA_W-1:0] cdb_value,
  output logic [OPT_W-1:0]  alu_opt,
  output logic [DATA_W-1:0] alu_rs1,
  output logic [DATA_W-1:0] alu_rs2,
  output logic [DATA_W-1:0] alu_imm,
  output logic [DATA_W-1:0] alu_pc,
  output logic [ROB_W-1:0]  alu_rob,
  input  logic [DATA_W-1:0] alu_res,
  input  logic [DATA_W-1:0] alu_pc_in,
  input  logic              alu_jump_in,
  input  logic [ROB_W-1:0]  alu_rob_in,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_res,
  output logic [DATA_W-1:0] out_pc,
  output logic              out_jump,
  output logic [ROB_W-1:0]  out_rob,
  input  logic              out_ready
);

  localparam int unsigned IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

  logic [RS_SIZE-1:0] busy_q, qj_busy_q, qk_busy_q;
  logic [OPT_W-1:0]   opt_q [RS_SIZE];
  logic [ROB_W-1:0]   rob_q [RS_SIZE];
  logic [ROB_W-1:0]   qj_q  [RS_SIZE];
  logic [ROB_W-1:0]   qk_q  [RS_SIZE];
  logic [DATA_W-1:0]  vj_q  [RS_SIZE];
  logic [DATA_W-1:0]  vk_q  [RS_SIZE];
  logic [DATA_W-1:0]  imm_q [RS_SIZE];
  logic [DATA_W-1:0]  pc_q  [RS_SIZE];

`ifdef ALU_SCHED_OLDEST_EN
  // older_q[i][j] set means entry i was dispatched before entry j.
  logic [RS_SIZE-1:0] older_q [RS_SIZE];
  logic               blocked;
`endif

  logic [OPT_W-1:0]  alu_opt_q;
  logic [DATA_W-1:0] alu_rs1_q, alu_rs2_q, alu_imm_q, alu_pc_q;
  logic [ROB_W-1:0]  alu_rob_q;
  logic              out_valid_q, out_jump_q;
  logic [DATA_W-1:0] out_res_q, out_pc_q;
  logic [ROB_W-1:0]  out_rob_q;

  logic [RS_SIZE-1:0] ready_vec;
  logic               free_found, sel_found;
  logic [IDX_W-1:0]   free_idx, sel_idx;
  logic               disp_fire, issue_fire, adv_out, adv_issue;
  logic               fwd_j, fwd_k;

  assign full_out  = &busy_q;
  assign ready_vec = busy_q & ~qj_busy_q & ~qk_busy_q;
  assign disp_fire = disp_valid & ~full_out;
  assign adv_out   = ~out_valid_q | out_ready;
  assign adv_issue = (alu_opt_q == '0) | adv_out;
  assign issue_fire = adv_issue & sel_found;
  assign fwd_j     = disp_qj_busy & cdb_valid & (cdb_rob == disp_qj);
  assign fwd_k     = disp_qk_busy & cdb_valid & (cdb_rob == disp_qk);

  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      if (!busy_q[i] && !free_found) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

`ifdef ALU_SCHED_OLDEST_EN
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    blocked   = 1'b0;
    for (int i = 0; i < RS_SIZE; i++) begin
      blocked = 1'b0;
      for (int j = 0; j < RS_SIZE; j++) begin
        if (ready_vec[j] && older_q[j][i]) blocked = 1'b1;
      end
      if (ready_vec[i] && !blocked && !sel_found) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
    end
  end
`else
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      if (ready_vec[i] && !sel_found) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
    end
  end
`endif

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      busy_q      <= '0;
      qj_busy_q   <= '0;
      qk_busy_q   <= '0;
      alu_opt_q   <= '0;
      alu_rs1_q   <= '0;
      alu_rs2_q   <= '0;
      alu_imm_q   <= '0;
      alu_pc_q    <= '0;
      alu_rob_q   <= '0;
      out_valid_q <= 1'b0;
      out_res_q   <= '0;
      out_pc_q    <= '0;
      out_jump_q  <= 1'b0;
      out_rob_q   <= '0;
`ifdef ALU_SCHED_OLDEST_EN
      for (int i = 0; i < RS_SIZE; i++) older_q[i] <= '0;
`endif
    end else if (rdy_in) begin
      if (flush_in) begin
        busy_q      <= '0;
        alu_opt_q   <= '0;
        out_valid_q <= 1'b0;
      end else begin
        for (int i = 0; i < RS_SIZE; i++) begin
          if (busy_q[i] && cdb_valid) begin
            if (qj_busy_q[i] && qj_q[i] == cdb_rob) begin
              qj_busy_q[i] <= 1'b0;
              vj_q[i]      <= cdb_value;
            end
            if (qk_busy_q[i] && qk_q[i] == cdb_rob) begin
              qk_busy_q[i] <= 1'b0;
              vk_q[i]      <= cdb_value;
            end
          end
        end

        if (issue_fire) busy_q[sel_idx] <= 1'b0;

        // The dispatch slot comes from registered busy bits, so it never aliases the issued slot.
        if (disp_fire) begin
          busy_q[free_idx]    <= 1'b1;
          opt_q[free_idx]     <= disp_opt;
          rob_q[free_idx]     <= disp_rob;
          qj_busy_q[free_idx] <= disp_qj_busy & ~fwd_j;
          qj_q[free_idx]      <= disp_qj;
          vj_q[free_idx]      <= fwd_j ? cdb_value : disp_vj;
          qk_busy_q[free_idx] <= disp_qk_busy & ~fwd_k;
          qk_q[free_idx]      <= disp_qk;
          vk_q[free_idx]      <= fwd_k ? cdb_value : disp_vk;
          imm_q[free_idx]     <= disp_imm;
          pc_q[free_idx]      <= disp_pc;
`ifdef ALU_SCHED_OLDEST_EN
          for (int j = 0; j < RS_SIZE; j++) older_q[j][free_idx] <= 1'b1;
          older_q[free_idx] <= '0;
`endif
        end

        if (adv_issue) begin
          if (sel_found) begin
            alu_opt_q <= opt_q[sel_idx];
            alu_rs1_q <= vj_q[sel_idx];
            alu_rs2_q <= vk_q[sel_idx];
            alu_imm_q <= imm_q[sel_idx];
            alu_pc_q  <= pc_q[sel_idx];
            alu_rob_q <= rob_q[sel_idx];
          end else begin
            alu_opt_q <= '0;
          end
        end

        if (adv_out) begin
          out_valid_q <= (alu_opt_q != '0);
          if (alu_opt_q != '0) begin
            out_res_q  <= alu_res;
            out_pc_q   <= alu_pc_in;
            out_jump_q <= alu_jump_in;
            out_rob_q  <= alu_rob_in;
          end
        end
      end
    end
  end

  assign alu_opt   = alu_opt_q;
  assign alu_rs1   = alu_rs1_q;
  assign alu_rs2   = alu_rs2_q;
  assign alu_imm   = alu_imm_q;
  assign alu_pc    = alu_pc_q;
  assign alu_rob   = alu_rob_q;
  assign out_valid = out_valid_q;
  assign out_res   = out_res_q;
  assign out_pc    = out_pc_q;
  assign out_jump  = out_jump_q;
  assign out_rob   = out_rob_q;

endmodule

// File: tb/tb_alu_rs_scheduler.sv
// Self-checking bench for alu_rs_scheduler: directed vectors, corner sequences and a random run
// against a tag-indexed instruction model; the ALU itself is modelled here.
module tb_alu_rs_scheduler;
  localparam int RS_SIZE = 8;
  localparam int DATA_W  = 32;
  localparam int ROB_W   = 4;
  localparam int OPT_W   = 6;

  logic clk = 1'b0;
  logic rst_in, rdy_in, flush_in;
  logic disp_valid, disp_qj_busy, disp_qk_busy;
  logic [OPT_W-1:0] disp_opt;
  logic [ROB_W-1:0] disp_rob, disp_qj, disp_qk;
  logic [DATA_W-1:0] disp_vj, disp_vk, disp_imm, disp_pc;
  logic full_out;
  logic cdb_valid;
  logic [ROB_W-1:0] cdb_rob;
  logic [DATA_W-1:0] cdb_value;
  logic [OPT_W-1:0] alu_opt;
  logic [DATA_W-1:0] alu_rs1, alu_rs2, alu_imm, alu_pc, alu_res, alu_pc_in;
  logic [ROB_W-1:0] alu_rob, alu_rob_in;
  logic alu_jump_in;
  logic out_valid, out_jump, out_ready;
  logic [DATA_W-1:0] out_res, out_pc;
  logic [ROB_W-1:0] out_rob;

  always #5 clk = ~clk;

  alu_rs_scheduler #(
    .RS_SIZE(RS_SIZE), .DATA_W(DATA_W), .ROB_W(ROB_W), .OPT_W(OPT_W)
  ) dut (
    .clk_in(clk), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
    .disp_valid(disp_valid), .disp_opt(disp_opt), .disp_rob(disp_rob),
    .disp_qj_busy(disp_qj_busy), .disp_qj(disp_qj), .disp_vj(disp_vj),
    .disp_qk_busy(disp_qk_busy), .disp_qk(disp_qk), .disp_vk(disp_vk),
    .disp_imm(disp_imm), .disp_pc(disp_pc), .full_out(full_out),
    .cdb_valid(cdb_valid), .cdb_rob(cdb_rob), .cdb_value(cdb_value),
    .alu_opt(alu_opt), .alu_rs1(alu_rs1), .alu_rs2(alu_rs2), .alu_imm(alu_imm),
    .alu_pc(alu_pc), .alu_rob(alu_rob), .alu_res(alu_res), .alu_pc_in(alu_pc_in),
    .alu_jump_in(alu_jump_in), .alu_rob_in(alu_rob_in), .out_valid(out_valid),
    .out_res(out_res), .out_pc(out_pc), .out_jump(out_jump), .out_rob(out_rob),
    .out_ready(out_ready)
  );

  // 1 ADD, 2 SUB, 3 ADDI, 4 XOR, 5 BEQ (taken target pc+imm), others AND.
  function automatic logic [DATA_W-1:0] alu_fn(input logic [OPT_W-1:0] op,
                                               input logic [DATA_W-1:0] a, b, imm);
    case (op)
      6'd1:    return a + b;
      6'd2:    return a - b;
      6'd3:    return a + imm;
      6'd4:    return a ^ b;
      6'd5:    return DATA_W'(a == b);
      default: return a & b;
    endcase
  endfunction

  function automatic logic jump_fn(input logic [OPT_W-1:0] op, input logic [DATA_W-1:0] a, b);
    return (op == 6'd5) && (a == b);
  endfunction

  assign alu_res     = alu_fn(alu_opt, alu_rs1, alu_rs2, alu_imm);
  assign alu_jump_in = jump_fn(alu_opt, alu_rs1, alu_rs2);
  assign alu_pc_in   = alu_jump_in ? alu_pc + alu_imm : alu_pc + 32'd4;
  assign alu_rob_in  = alu_rob;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic clr_in();
    disp_valid = 1'b0; disp_qj_busy = 1'b0; disp_qk_busy = 1'b0;
    cdb_valid = 1'b0; flush_in = 1'b0;
  endtask

  task automatic drive_disp(input logic [OPT_W-1:0] op, input logic [ROB_W-1:0] rob,
                            input logic qjb, input logic [ROB_W-1:0] qj,
                            input logic [DATA_W-1:0] vj, input logic qkb,
                            input logic [ROB_W-1:0] qk, input logic [DATA_W-1:0] vk,
                            input logic [DATA_W-1:0] imm, input logic [DATA_W-1:0] pc);
    disp_valid = 1'b1; disp_opt = op; disp_rob = rob;
    disp_qj_busy = qjb; disp_qj = qj; disp_vj = vj;
    disp_qk_busy = qkb; disp_qk = qk; disp_vk = vk;
    disp_imm = imm; disp_pc = pc;
  endtask

  typedef struct {
    logic [OPT_W-1:0]  op;
    logic [DATA_W-1:0] vj, vk, imm, pc;
    logic [ROB_W-1:0]  rob;
    logic [DATA_W-1:0] res;
    logic              jump;
    logic [DATA_W-1:0] npc;
  } vec_t;

  localparam int NV = 7;
  vec_t vecs [NV];

  // Random-phase model, indexed by ROB tag.
  logic              m_out [16];
  logic [OPT_W-1:0]  m_op  [16];
  logic              m_qjb [16];
  logic              m_qkb [16];
  logic [ROB_W-1:0]  m_qj  [16];
  logic [ROB_W-1:0]  m_qk  [16];
  logic [DATA_W-1:0] m_vj  [16];
  logic [DATA_W-1:0] m_vk  [16];
  logic [DATA_W-1:0] m_imm [16];
  logic [DATA_W-1:0] m_pc  [16];
  int                cnt;
  logic              held, draining;
  logic [ROB_W-1:0]  h_rob;
  logic [DATA_W-1:0] h_res;
  logic [ROB_W-1:0]  got [8];
  int                n_got;
  logic [DATA_W-1:0] exp_res;
  logic              exp_jump;

  initial begin
    vecs[0] = '{6'd1, 32'd5, 32'd7, 32'd0, 32'h100, 4'd3, 32'd12, 1'b0, 32'h104};
    vecs[1] = '{6'd2, 32'd10, 32'd4, 32'd0, 32'h200, 4'd2, 32'd6, 1'b0, 32'h204};
    vecs[2] = '{6'd3, 32'h10, 32'hdead, 32'h20, 32'h300, 4'd5, 32'h30, 1'b0, 32'h304};
    vecs[3] = '{6'd4, 32'hff00, 32'h0ff0, 32'd0, 32'h400, 4'd7, 32'hf0f0, 1'b0, 32'h404};
    vecs[4] = '{6'd5, 32'd9, 32'd9, 32'h40, 32'h500, 4'd1, 32'd1, 1'b1, 32'h540};
    vecs[5] = '{6'd5, 32'd9, 32'd8, 32'h40, 32'h600, 4'd6, 32'd0, 1'b0, 32'h604};
    vecs[6] = '{6'd2, 32'd0, 32'd1, 32'd0, 32'h0, 4'd15, 32'hffffffff, 1'b0, 32'h4};

    rst_in = 1'b0; rdy_in = 1'b1; out_ready = 1'b1;
    disp_opt = '0; disp_rob = '0; disp_qj = '0; disp_qk = '0;
    disp_vj = '0; disp_vk = '0; disp_imm = '0; disp_pc = '0;
    cdb_rob = '0; cdb_value = '0;
    clr_in();
    repeat (2) nxt();
    chk("rst_full", full_out, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_alu_opt", alu_opt, 0);
    chk("rst_alu_rs1", alu_rs1, 0);
    chk("rst_out_res", out_res, 0);
    chk("rst_out_jump", out_jump, 0);
    chk("rst_out_rob", out_rob, 0);
    rst_in = 1'b1;
    nxt();

    // Single ready instructions: out_valid two edges after dispatch, one-cycle pulse.
    for (int v = 0; v < NV; v++) begin
      drive_disp(vecs[v].op, vecs[v].rob, 1'b0, '0, vecs[v].vj, 1'b0, '0, vecs[v].vk,
                 vecs[v].imm, vecs[v].pc);
      nxt(); clr_in();
      chk("vec_early_valid", out_valid, 0);
      nxt();
      chk("vec_alu_opt", alu_opt, vecs[v].op);
      nxt();
      chk("vec_valid", out_valid, 1);
      chk("vec_res", out_res, vecs[v].res);
      chk("vec_rob", out_rob, vecs[v].rob);
      chk("vec_jump", out_jump, vecs[v].jump);
      chk("vec_pc", out_pc, vecs[v].npc);
      nxt();
      chk("vec_pulse", out_valid, 0);
    end

    // Wakeup latency: SUB waiting on tag 1, broadcast two cycles later.
    drive_disp(6'd2, 4'd2, 1'b1, 4'd1, 32'd0, 1'b0, '0, 32'd4, 32'd0, 32'h700);
    nxt(); clr_in();
    nxt();
    cdb_valid = 1'b1; cdb_rob = 4'd1; cdb_value = 32'd10;
    nxt(); clr_in();
    chk("wake_not_yet", out_valid, 0);
    nxt();
    chk("wake_not_yet2", out_valid, 0);
    nxt();
    chk("wake_valid", out_valid, 1);
    chk("wake_res", out_res, 6);
    chk("wake_rob", out_rob, 2);
    nxt();

    // Fill all entries pending on tag 9; a 9th dispatch must be dropped.
    for (int k = 0; k < 8; k++) begin
      drive_disp(6'd1, ROB_W'(k), 1'b1, 4'd9, 32'd0, 1'b0, '0, DATA_W'(k + 1), 32'd0, 32'h800);
      nxt();
    end
    clr_in();
    chk("fill_full", full_out, 1);
    drive_disp(6'd1, 4'd8, 1'b1, 4'd9, 32'd0, 1'b0, '0, 32'd99, 32'd0, 32'h800);
    nxt(); clr_in();
    chk("fill_full_after9", full_out, 1);
    cdb_valid = 1'b1; cdb_rob = 4'd9; cdb_value = 32'd100;
    nxt(); clr_in();
    chk("fill_full_woken", full_out, 1);
    nxt();
    chk("fill_full_drop", full_out, 0);
    nxt();
    for (int k = 0; k < 8; k++) begin
      chk("fill_stream_valid", out_valid, 1);
      chk("fill_stream_rob", out_rob, k);
      chk("fill_stream_res", out_res, 101 + k);
      nxt();
    end
    chk("fill_no_ninth", out_valid, 0);

    // Back-pressure: three ready entries, output stalled for five cycles.
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive_disp(6'd1, ROB_W'(10 + k), 1'b0, '0, 32'd1, 1'b0, '0, DATA_W'(10 + k), 32'd0, 32'h0);
      nxt();
    end
    clr_in();
    for (int k = 0; k < 5; k++) begin
      chk("stall_valid", out_valid, 1);
      chk("stall_rob", out_rob, 10);
      chk("stall_res", out_res, 11);
      nxt();
    end
    out_ready = 1'b1;
    n_got = 0;
    for (int k = 0; k < 6; k++) begin
      if (out_valid && n_got < 8) begin got[n_got] = out_rob; n_got++; end
      nxt();
    end
    chk("stall_count", n_got, 3);
    chk("stall_first", got[0], 10);
    chk("stall_second", got[1], 11);
    chk("stall_third", got[2], 12);

    // Issue order when idx1 (older) and idx0 (younger) wake together.
    drive_disp(6'd1, 4'd1, 1'b0, '0, 32'd1, 1'b0, '0, 32'd1, 32'd0, 32'h0);
    nxt();
    drive_disp(6'd1, 4'd2, 1'b1, 4'd9, 32'd0, 1'b0, '0, 32'd1, 32'd0, 32'h0);
    nxt();
    drive_disp(6'd1, 4'd3, 1'b1, 4'd9, 32'd0, 1'b0, '0, 32'd2, 32'd0, 32'h0);
    nxt(); clr_in();
    cdb_valid = 1'b1; cdb_rob = 4'd9; cdb_value = 32'd50;
    nxt(); clr_in();
    n_got = 0;
    for (int k = 0; k < 10; k++) begin
      if (out_valid && n_got < 8) begin got[n_got] = out_rob; n_got++; end
      nxt();
    end
    chk("order_count", n_got, 2);
`ifdef ALU_SCHED_OLDEST_EN
    chk("order_first", got[0], 2);
    chk("order_second", got[1], 3);
`else
    chk("order_first", got[0], 3);
    chk("order_second", got[1], 2);
`endif

    // Flush with four busy entries and a stalled result.
    out_ready = 1'b0;
    drive_disp(6'd1, 4'd4, 1'b0, '0, 32'd1, 1'b0, '0, 32'd1, 32'd0, 32'h0);
    nxt();
    for (int k = 0; k < 4; k++) begin
      drive_disp(6'd1, ROB_W'(5 + k), 1'b1, 4'd13, 32'd0, 1'b0, '0, 32'd1, 32'd0, 32'h0);
      nxt();
    end
    clr_in();
    chk("flush_pre_valid", out_valid, 1);
    flush_in = 1'b1;
    nxt(); clr_in();
    chk("flush_full", full_out, 0);
    chk("flush_valid", out_valid, 0);
    chk("flush_alu_opt", alu_opt, 0);
    out_ready = 1'b1;
    cdb_valid = 1'b1; cdb_rob = 4'd13; cdb_value = 32'd5;
    nxt(); clr_in();
    n_got = 0;
    for (int k = 0; k < 6; k++) begin
      if (out_valid) n_got++;
      nxt();
    end
    chk("flush_no_stray", n_got, 0);

    // Reset in the middle of a stream.
    for (int k = 0; k < 4; k++) begin
      drive_disp(6'd1, ROB_W'(k), 1'b0, '0, 32'd3, 1'b0, '0, 32'd3, 32'd0, 32'h0);
      if (k == 3) rst_in = 1'b0;
      nxt();
    end
    rst_in = 1'b1; clr_in();
    chk("mrst_valid", out_valid, 0);
    chk("mrst_alu_opt", alu_opt, 0);
    chk("mrst_full", full_out, 0);
    chk("mrst_out_res", out_res, 0);
    n_got = 0;
    for (int k = 0; k < 6; k++) begin
      if (out_valid) n_got++;
      nxt();
    end
    chk("mrst_no_stray", n_got, 0);

    // Random traffic; tags 0..7 name instructions, 8..15 are external producers.
    for (int r = 0; r < 16; r++) m_out[r] = 1'b0;
    cnt = 0; held = 1'b0; h_rob = '0; h_res = '0;
    for (int cyc = 0; cyc < 1600; cyc++) begin
      if (out_valid) begin
        if (held) begin
          chk("rand_hold_rob", out_rob, h_rob);
          chk("rand_hold_res", out_res, h_res);
        end else begin
          int r;
          r = int'(out_rob);
          chk("rand_known_rob", m_out[r], 1);
          if (m_out[r]) begin
            exp_res  = alu_fn(m_op[r], m_vj[r], m_vk[r], m_imm[r]);
            exp_jump = jump_fn(m_op[r], m_vj[r], m_vk[r]);
            chk("rand_ops_ready", {m_qjb[r], m_qkb[r]}, 0);
            chk("rand_res", out_res, exp_res);
            chk("rand_jump", out_jump, exp_jump);
            chk("rand_pc", out_pc, exp_jump ? m_pc[r] + m_imm[r] : m_pc[r] + 32'd4);
            m_out[r] = 1'b0;
            cnt--;
          end
        end
      end

      clr_in();
      draining  = (cyc >= 1400);
      rdy_in    = draining ? 1'b1 : ($urandom_range(0, 9) != 0);
      out_ready = draining ? 1'b1 : ($urandom_range(0, 9) < 7);
      if (rdy_in && (draining || $urandom_range(0, 1) == 1)) begin
        cdb_valid = 1'b1;
        cdb_rob   = draining ? ROB_W'(8 + cyc % 8) : ROB_W'(8 + $urandom_range(0, 7));
        cdb_value = $urandom;
      end
      held  = out_valid && !(out_ready && rdy_in);
      h_rob = out_rob;
      h_res = out_res;

      if (cdb_valid) begin
        for (int r = 0; r < 8; r++) begin
          if (m_out[r] && m_qjb[r] && m_qj[r] == cdb_rob) begin
            m_qjb[r] = 1'b0; m_vj[r] = cdb_value;
          end
          if (m_out[r] && m_qkb[r] && m_qk[r] == cdb_rob) begin
            m_qkb[r] = 1'b0; m_vk[r] = cdb_value;
          end
        end
      end

      if (rdy_in && !draining && cnt < 6 && $urandom_range(0, 9) < 6) begin
        int t, st;
        t  = -1;
        st = $urandom_range(0, 7);
        for (int k = 0; k < 8; k++) begin
          if (t < 0 && !m_out[(st + k) % 8]) t = (st + k) % 8;
        end
        m_op[t]  = OPT_W'($urandom_range(1, 6));
        m_qjb[t] = ($urandom_range(0, 2) == 0);
        m_qkb[t] = ($urandom_range(0, 2) == 0);
        m_qj[t]  = ROB_W'(8 + $urandom_range(0, 7));
        m_qk[t]  = ROB_W'(8 + $urandom_range(0, 7));
        m_vj[t]  = ($urandom_range(0, 3) == 0) ? 32'd7 : $urandom;
        m_vk[t]  = ($urandom_range(0, 3) == 0) ? 32'd7 : $urandom;
        m_imm[t] = $urandom;
        m_pc[t]  = {$urandom_range(0, 65535), 2'b00};
        drive_disp(m_op[t], ROB_W'(t), m_qjb[t], m_qj[t], m_vj[t], m_qkb[t], m_qk[t],
                   m_vk[t], m_imm[t], m_pc[t]);
        if (cdb_valid && m_qjb[t] && m_qj[t] == cdb_rob) begin
          m_qjb[t] = 1'b0; m_vj[t] = cdb_value;
        end
        if (cdb_valid && m_qkb[t] && m_qk[t] == cdb_rob) begin
          m_qkb[t] = 1'b0; m_vk[t] = cdb_value;
        end
        m_out[t] = 1'b1;
        cnt++;
      end
      nxt();
    end
    clr_in();
    chk("rand_drained", cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
